// File: rtl/shift_add_mul_seq.sv
// -----------------------------------------------------------------------------
// shift_add_mul_seq
//
// Sequential unsigned shift-and-add multiplier. One operand pair is accepted
// over a valid/ready handshake. A single shared adder then folds in one
// partial product per cycle for N cycles. The 2N-bit product is then held on a
// valid/ready output until the consumer takes it.
//
// Ports
//   clock        : single clock, rising edge
//   reset        : asynchronous, active-high reset
//   io_in_valid  : operand pair valid
//   io_in_ready  : block can accept an operand pair (IDLE)
//   io_a         : multiplicand, N bits, unsigned
//   io_b         : multiplier, N bits, unsigned
//   io_abort     : synchronous cancel while RUN or DONE
//   io_out_valid : io_result valid (DONE)
//   io_out_ready : consumer accepts the result
//   io_result    : product, 2N bits
//   io_busy      : high in RUN or DONE
// -----------------------------------------------------------------------------
module shift_add_mul_seq #(
    parameter int N = 4
) (
    input  logic           clock,
    input  logic           reset,
    input  logic           io_in_valid,
    output logic           io_in_ready,
    input  logic [N-1:0]   io_a,
    input  logic [N-1:0]   io_b,
    input  logic           io_abort,
    output logic           io_out_valid,
    input  logic           io_out_ready,
    output logic [2*N-1:0] io_result,
    output logic           io_busy
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [N-1:0]     r_a;
    logic [N-1:0]     r_b;
    logic [2*N-1:0]   r_acc;
    logic [CW-1:0]    r_cnt;

    logic [2*N-1:0]   w_addend;
    logic             w_last;

    // The partial product for the current multiplier bit. The carry out of the
    // 2N-bit sum is dropped: (2^N-1)^2 always fits in 2N bits.
    assign w_addend = {{N{1'b0}}, r_a} << r_cnt;
    assign w_last   = (r_cnt == CW'(N - 1));

    always_ff @(posedge clock or posedge reset) begin
        // NOTE: state registers use non-blocking assignments so every register
        // samples pre-edge values; blocking here would create ordering races.
        if (reset) begin
            r_state <= S_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    // io_abort is ignored here; only the input handshake matters.
                    if (io_in_valid) begin
                        r_a     <= io_a;
                        r_b     <= io_b;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (io_abort) begin
                        r_acc   <= '0;
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                    end else begin
                        if (r_b[r_cnt]) begin
                            r_acc <= r_acc + w_addend;
                        end
                        // Always exactly N cycles; zero multiplier bits do not
                        // shorten the run.
                        if (w_last) begin
                            r_cnt   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + CW'(1);
                        end
                    end
                end
                S_DONE: begin
                    // Abort beats the output handshake: the visible result is
                    // dropped and the accumulator cleared.
                    if (io_abort) begin
                        r_acc   <= '0;
                        r_state <= S_IDLE;
                    end else if (io_out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                // NOTE: the unused fourth encoding recovers to IDLE rather than
                // locking up the block.
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // All outputs decode registers only, so no input reaches an output
    // combinationally.
    assign io_in_ready  = (r_state == S_IDLE);
    assign io_out_valid = (r_state == S_DONE);
    assign io_busy      = (r_state != S_IDLE);
    assign io_result    = r_acc;

endmodule

// File: tb/tb_shift_add_mul_seq.sv
// -----------------------------------------------------------------------------
// tb_shift_add_mul_seq
//
// Self-checking bench for shift_add_mul_seq (N = 4). Each scenario task drives
// its own stimulus and compares against a plain-arithmetic reference (a * b,
// result visible N+1 cycles after the accept cycle).
// -----------------------------------------------------------------------------
module tb_shift_add_mul_seq;

    localparam int N = 4;

    logic           clock;
    logic           reset;
    logic           io_in_valid;
    logic           io_in_ready;
    logic [N-1:0]   io_a;
    logic [N-1:0]   io_b;
    logic           io_abort;
    logic           io_out_valid;
    logic           io_out_ready;
    logic [2*N-1:0] io_result;
    logic           io_busy;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    shift_add_mul_seq #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .io_in_valid  (io_in_valid),
        .io_in_ready  (io_in_ready),
        .io_a         (io_a),
        .io_b         (io_b),
        .io_abort     (io_abort),
        .io_out_valid (io_out_valid),
        .io_out_ready (io_out_ready),
        .io_result    (io_result),
        .io_busy      (io_busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Reference model: the product as plain integer arithmetic.
    function automatic logic [2*N-1:0] ref_mul(input logic [N-1:0] a, input logic [N-1:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[2*N-1:0];
    endfunction

    // Advance to 1 time unit after the next rising edge (sample/drive point).
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present an operand pair until accepted; c_acc is the handshake cycle.
    task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b,
                         output int c_acc, output bit ok);
        ok    = 1'b0;
        c_acc = 0;
        for (int i = 0; i < 20; i++) begin
            if (io_in_ready) begin
                io_a        = a;
                io_b        = b;
                io_in_valid = 1'b1;
                c_acc       = cyc;
                step();
                io_in_valid = 1'b0;
                ok          = 1'b1;
                return;
            end
            step();
        end
    endtask

    // Wait (bounded) for io_out_valid; c_v is the first cycle it is seen.
    task automatic wait_valid(output int c_v, output bit ok);
        ok  = 1'b0;
        c_v = 0;
        for (int i = 0; i < 30; i++) begin
            if (io_out_valid) begin
                c_v = cyc;
                ok  = 1'b1;
                return;
            end
            step();
        end
    endtask

    task automatic test_reset();
        checks++;
        if (io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_result !== '0) begin
            errors++;
            $display("FAIL reset_state: in_ready=%b out_valid=%b busy=%b result=%0d, want 1 0 0 0",
                     io_in_ready, io_out_valid, io_busy, io_result);
        end
    endtask

    task automatic test_basic();
        int c_acc, c_v;
        bit ok;
        io_out_ready = 1'b1;
        issue(4'd15, 4'd15, c_acc, ok);
        checks++;
        if (!ok || io_in_ready !== 1'b0 || io_busy !== 1'b1) begin
            errors++;
            $display("FAIL basic_accept: ok=%b in_ready=%b busy=%b, want 1 0 1", ok, io_in_ready, io_busy);
        end
        wait_valid(c_v, ok);
        checks++;
        if (!ok || (c_v - c_acc) != N + 1) begin
            errors++;
            $display("FAIL basic_latency: ok=%b latency=%0d, want %0d", ok, c_v - c_acc, N + 1);
        end
        checks++;
        if (io_result !== 8'd225) begin
            errors++;
            $display("FAIL basic_result: got %0d, want 225", io_result);
        end
        step();
        checks++;
        if (io_in_ready !== 1'b1 || io_busy !== 1'b0 || io_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_idle: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                     io_in_ready, io_busy, io_out_valid);
        end
    endtask

    task automatic test_zero_identity();
        logic [N-1:0] ta [4];
        logic [N-1:0] tb [4];
        int c_acc, c_v;
        bit ok, ok2;
        ta[0] = 4'd0;  tb[0] = 4'd13;
        ta[1] = 4'd11; tb[1] = 4'd1;
        ta[2] = 4'd15; tb[2] = 4'd0;
        ta[3] = 4'd1;  tb[3] = 4'd15;
        io_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(ta[i], tb[i], c_acc, ok);
            wait_valid(c_v, ok2);
            checks++;
            if (!ok || !ok2 || (c_v - c_acc) != N + 1 || io_result !== ref_mul(ta[i], tb[i])) begin
                errors++;
                $display("FAIL zero_identity[%0d]: a=%0d b=%0d got %0d lat %0d, want %0d lat %0d",
                         i, ta[i], tb[i], io_result, c_v - c_acc, ref_mul(ta[i], tb[i]), N + 1);
            end
            step();
        end
    endtask

    task automatic test_backpressure();
        int c_acc, c_v, bad;
        bit ok, ok2;
        io_out_ready = 1'b0;
        issue(4'd6, 4'd7, c_acc, ok);
        wait_valid(c_v, ok2);
        checks++;
        if (!ok || !ok2 || io_result !== 8'd42) begin
            errors++;
            $display("FAIL bp_first: ok=%b/%b got %0d, want 42", ok, ok2, io_result);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (io_result !== 8'd42 || io_out_valid !== 1'b1 || io_in_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bp_hold: %0d unstable cycles, want 0 (last result %0d)", bad, io_result);
        end
        io_out_ready = 1'b1;
        step();
        io_out_ready = 1'b0;
        checks++;
        if (io_in_ready !== 1'b1 || io_busy !== 1'b0 || io_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b busy=%b out_valid=%b, want 1 0 0",
                     io_in_ready, io_busy, io_out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [2*N-1:0] expq[$];
        int  idx, n_out, c_hs1, c_acc2, extra;
        bit  acc_now, out_now;
        logic [2*N-1:0] exp_v;
        expq = {8'd15, 8'd90};
        idx = 0; n_out = 0; c_hs1 = -100; c_acc2 = -200;
        io_out_ready = 1'b1;
        io_a = 4'd3; io_b = 4'd5;
        io_in_valid = 1'b1;
        for (int i = 0; i < 40 && n_out < 2; i++) begin
            acc_now = io_in_valid && io_in_ready;
            out_now = io_out_valid && io_out_ready;
            if (acc_now && idx == 1) c_acc2 = cyc;
            if (out_now) begin
                exp_v = (expq.size() != 0) ? expq.pop_front() : 'x;
                checks++;
                if (io_result !== exp_v) begin
                    errors++;
                    $display("FAIL b2b_result[%0d]: got %0d, want %0d", n_out, io_result, exp_v);
                end
                if (n_out == 0) c_hs1 = cyc;
                n_out++;
            end
            step();
            if (acc_now) begin
                idx++;
                if (idx == 1) begin
                    io_a = 4'd9; io_b = 4'd10;
                end else begin
                    io_in_valid = 1'b0;
                end
            end
        end
        io_in_valid = 1'b0;
        checks++;
        if (n_out != 2 || idx != 2) begin
            errors++;
            $display("FAIL b2b_count: results=%0d accepts=%0d, want 2 2", n_out, idx);
        end
        checks++;
        if (c_acc2 != c_hs1 + 1) begin
            errors++;
            $display("FAIL b2b_timing: second accept cycle %0d, want %0d", c_acc2, c_hs1 + 1);
        end
        extra = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (io_out_valid || io_busy) extra++;
        end
        checks++;
        if (extra != 0) begin
            errors++;
            $display("FAIL b2b_no_dup: %0d busy/valid cycles after drain, want 0", extra);
        end
    endtask

    task automatic test_abort();
        int c_acc, c_v, seen;
        bit ok, ok2;
        io_out_ready = 1'b1;
        issue(4'd12, 4'd12, c_acc, ok);   // now in RUN cycle 1
        step();                            // RUN cycle 2
        io_abort = 1'b1;
        step();
        io_abort = 1'b0;
        checks++;
        if (!ok || io_busy !== 1'b0 || io_in_ready !== 1'b1 || io_result !== '0 || io_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_run: busy=%b in_ready=%b result=%0d out_valid=%b, want 0 1 0 0",
                     io_busy, io_in_ready, io_result, io_out_valid);
        end
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (io_out_valid) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_no_valid: %0d valid cycles, want 0", seen);
        end
        issue(4'd2, 4'd3, c_acc, ok);
        wait_valid(c_v, ok2);
        checks++;
        if (!ok || !ok2 || io_result !== 8'd6 || (c_v - c_acc) != N + 1) begin
            errors++;
            $display("FAIL abort_next: got %0d lat %0d, want 6 lat %0d", io_result, c_v - c_acc, N + 1);
        end
        step();
        // Abort and out_ready together in DONE: abort wins, accumulator cleared.
        io_out_ready = 1'b0;
        issue(4'd4, 4'd4, c_acc, ok);
        wait_valid(c_v, ok2);
        io_abort     = 1'b1;
        io_out_ready = 1'b1;
        step();
        io_abort = 1'b0;
        checks++;
        if (!ok || !ok2 || io_busy !== 1'b0 || io_result !== '0) begin
            errors++;
            $display("FAIL abort_done: busy=%b result=%0d, want 0 0", io_busy, io_result);
        end
        // Plain handshake in DONE leaves the product in the accumulator.
        issue(4'd4, 4'd4, c_acc, ok);
        wait_valid(c_v, ok2);
        step();
        checks++;
        if (!ok || !ok2 || io_busy !== 1'b0 || io_result !== 8'd16) begin
            errors++;
            $display("FAIL handshake_keep: busy=%b result=%0d, want 0 16", io_busy, io_result);
        end
    endtask

    task automatic test_async_reset();
        int c_acc, c_v, seen;
        bit ok, ok2;
        io_out_ready = 1'b1;
        issue(4'd10, 4'd11, c_acc, ok);   // RUN cycle 1
        step();                            // RUN cycle 2
        step();                            // RUN cycle 3
        #2 reset = 1'b1;
        #1;
        checks++;
        if (!ok || io_in_ready !== 1'b1 || io_out_valid !== 1'b0 || io_busy !== 1'b0 || io_result !== '0) begin
            errors++;
            $display("FAIL async_reset: in_ready=%b out_valid=%b busy=%b result=%0d, want 1 0 0 0",
                     io_in_ready, io_out_valid, io_busy, io_result);
        end
        step();
        @(negedge clock);
        reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (io_out_valid || io_busy) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL reset_no_partial: %0d busy/valid cycles, want 0", seen);
        end
        issue(4'd5, 4'd5, c_acc, ok);
        wait_valid(c_v, ok2);
        checks++;
        if (!ok || !ok2 || io_result !== 8'd25) begin
            errors++;
            $display("FAIL reset_next: got %0d, want 25", io_result);
        end
        step();
    endtask

    task automatic test_random();
        logic [N-1:0] a, b;
        int c_acc, c_v, hold, bad;
        bit ok, ok2;
        for (int k = 0; k < 16; k++) begin
            a = N'($urandom);
            b = N'($urandom);
            io_out_ready = 1'b0;
            // Inputs wander after the accept edge; the product must not care.
            issue(a, b, c_acc, ok);
            io_a = N'($urandom);
            io_b = N'($urandom);
            wait_valid(c_v, ok2);
            checks++;
            if (!ok || !ok2 || (c_v - c_acc) != N + 1 || io_result !== ref_mul(a, b)) begin
                errors++;
                $display("FAIL random[%0d]: a=%0d b=%0d got %0d lat %0d, want %0d lat %0d",
                         k, a, b, io_result, c_v - c_acc, ref_mul(a, b), N + 1);
            end
            hold = int'($urandom_range(0, 3));
            bad  = 0;
            for (int i = 0; i < hold; i++) begin
                step();
                if (io_result !== ref_mul(a, b) || !io_out_valid) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL random_hold[%0d]: %0d unstable cycles, want 0", k, bad);
            end
            io_out_ready = 1'b1;
            step();
        end
        io_out_ready = 1'b0;
    endtask

    initial begin
        reset        = 1'b1;
        io_in_valid  = 1'b0;
        io_a         = '0;
        io_b         = '0;
        io_abort     = 1'b0;
        io_out_ready = 1'b0;
        #12;
        test_reset();
        @(negedge clock);
        reset = 1'b0;
        step();
        test_basic();
        test_zero_identity();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
